// File: rtl/sipo_packer_pkg.sv
// Shared FSM encodings and default frame width
// for the serial-in parallel-out packer.
package sipo_packer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    PAR   = 2'b10
  } state_e;

endpackage

// File: rtl/sipo_packer_word_hold.sv
// Output holding register: keeps a finished word until consumed,
// replaces it on a same-edge handoff, flags words dropped while full.
module word_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             done_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             perr_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             perr_o,
  output logic             dvalid_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             perr_q, perr_d;
  logic             dvalid_q, dvalid_d;
  logic             ovf_q, ovf_d;

  // Load on completion when the slot is free or being drained this edge.
  always_comb begin
    dout_d   = dout_q;
    perr_d   = perr_q;
    dvalid_d = dvalid_q;
    ovf_d    = 1'b0;
    if (dvalid_q && ready_i) begin
      dvalid_d = 1'b0;
    end
    if (done_i) begin
      if (!dvalid_q || ready_i) begin
        dout_d   = word_i;
        perr_d   = perr_i;
        dvalid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Holding register state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dout_q   <= '0;
      perr_q   <= 1'b0;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      perr_q   <= perr_d;
      dvalid_q <= dvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign dout_o   = dout_q;
  assign perr_o   = perr_q;
  assign dvalid_o = dvalid_q;
  assign ovf_o    = ovf_q;

endmodule

// File: rtl/sipo_packer.sv
// Serial-in parallel-out packer: start bit, WIDTH data bits LSB
// first, optional even parity; finished words go to word_hold.
module sipo_packer
  import sipo_packer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             SIN,
  input  logic             SVALID,
  output logic [WIDTH-1:0] DOUT,
  output logic             PERR,
  output logic             DVALID,
  input  logic             DREADY,
  output logic             BUSY,
  output logic             OVF
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             busy_q;
  logic             done;
  logic             perr_new;

  // Next-state, bit capture and word-completion decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    done     = 1'b0;
    perr_new = 1'b0;
    if (SVALID) begin
      unique case (state_q)
        IDLE: begin
          if (!SIN) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(i)) sh_d[i] = SIN;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            if (PARITY_EN) begin
              state_d = PAR;
            end else begin
              state_d = IDLE;
              done    = 1'b1;
            end
          end
        end
        PAR: begin
          done     = 1'b1;
          perr_new = (^sh_q) ^ SIN;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, counter, shift register and registered busy flag.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign BUSY = busy_q;

  word_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk_i   (CLK),
    .rst_ni  (RESETB),
    .done_i  (done),
    .word_i  (sh_d),
    .perr_i  (perr_new),
    .ready_i (DREADY),
    .dout_o  (DOUT),
    .perr_o  (PERR),
    .dvalid_o(DVALID),
    .ovf_o   (OVF)
  );

endmodule

// File: tb/tb_sipo_packer.sv
// Directed self-checking bench for sipo_packer
// (parity and no-parity instances share stimulus).
module tb_sipo_packer;
  import sipo_packer_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic         CLK = 1'b0;
  logic         RESETB = 1'b0;
  logic         SIN = 1'b1;
  logic         SVALID = 1'b0;
  logic         DREADY = 1'b0;
  logic [W-1:0] DOUT, DOUT2;
  logic         PERR, PERR2;
  logic         DVALID, DVALID2;
  logic         BUSY, BUSY2;
  logic         OVF, OVF2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  sipo_packer #(.WIDTH(W), .PARITY_EN(1'b1)) dut (
    .CLK(CLK), .RESETB(RESETB), .SIN(SIN), .SVALID(SVALID),
    .DOUT(DOUT), .PERR(PERR), .DVALID(DVALID), .DREADY(DREADY),
    .BUSY(BUSY), .OVF(OVF)
  );

  sipo_packer #(.WIDTH(W), .PARITY_EN(1'b0)) dut2 (
    .CLK(CLK), .RESETB(RESETB), .SIN(SIN), .SVALID(SVALID),
    .DOUT(DOUT2), .PERR(PERR2), .DVALID(DVALID2), .DREADY(DREADY),
    .BUSY(BUSY2), .OVF(OVF2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, return 1ns after the rising edge.
  task automatic step(input logic v, input logic b);
    @(negedge CLK);
    SVALID = v;
    SIN    = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESETB = 1'b0;
    SVALID = 1'b0;
    SIN    = 1'b1;
    @(negedge CLK);
    RESETB = 1'b1;
  endtask

  task automatic consume();
    @(negedge CLK);
    SVALID = 1'b0;
    DREADY = 1'b1;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    DREADY = 1'b0;
  endtask

  logic [7:0] d;

  initial begin
    // Reset state
    #2;
    chk("rst_dvalid", 32'(DVALID), 32'd0);
    chk("rst_dout",   32'(DOUT),   32'd0);
    chk("rst_busy",   32'(BUSY),   32'd0);
    chk("rst_ovf",    32'(OVF),    32'd0);
    chk("rst_perr",   32'(PERR),   32'd0);
    do_reset();

    // A5, parity bit 0
    d = 8'hA5;
    step(1'b1, 1'b0);
    chk("a5_busy_start", 32'(BUSY), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b1, d[i]);
    chk("a5_dvalid_9", 32'(DVALID), 32'd0);
    step(1'b1, 1'b0);
    chk("a5_dvalid", 32'(DVALID), 32'd1);
    chk("a5_dout",   32'(DOUT),   32'hA5);
    chk("a5_perr",   32'(PERR),   32'd0);
    chk("a5_busy",   32'(BUSY),   32'd0);
    step(1'b0, 1'b1);
    chk("a5_hold", 32'(DOUT), 32'hA5);
    consume();
    chk("a5_consumed", 32'(DVALID), 32'd0);

    // A5, parity bit 1 -> parity error
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, d[i]);
    step(1'b1, 1'b1);
    chk("a5p_dout", 32'(DOUT), 32'hA5);
    chk("a5p_perr", 32'(PERR), 32'd1);
    consume();

    // 3C with SVALID toggling, idle cycle before every bit
    d = 8'h3C;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, ~d[i]);
      chk("3c_cnt_hold", 32'(dut.cnt_q), 32'(i));
      chk("3c_busy_hold", 32'(BUSY), 32'd1);
      step(1'b1, d[i]);
    end
    step(1'b0, 1'b1);
    chk("3c_state_hold", 32'(dut.state_q), 32'(PAR));
    chk("3c_dvalid_19", 32'(DVALID), 32'd0);
    step(1'b1, 1'b0);
    chk("3c_dvalid_20", 32'(DVALID), 32'd1);
    chk("3c_dout", 32'(DOUT), 32'h3C);
    chk("3c_perr", 32'(PERR), 32'd0);
    consume();

    // 01 then FF with DREADY=0: second word dropped
    d = 8'h01;
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, d[i]);
    step(1'b1, 1'b1);
    chk("01_dout", 32'(DOUT), 32'h01);
    chk("01_ovf",  32'(OVF),  32'd0);
    d = 8'hFF;
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, d[i]);
    step(1'b1, 1'b0);
    chk("ff_drop_dout", 32'(DOUT),   32'h01);
    chk("ff_drop_ovf",  32'(OVF),    32'd1);
    chk("ff_drop_dv",   32'(DVALID), 32'd1);
    step(1'b0, 1'b1);
    chk("ff_ovf_pulse", 32'(OVF),  32'd0);
    chk("ff_keep_dout", 32'(DOUT), 32'h01);
    consume();

    // 01 then FF with DREADY=1 on the completion edge: handoff
    d = 8'h01;
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, d[i]);
    step(1'b1, 1'b1);
    d = 8'hFF;
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, d[i]);
    @(negedge CLK);
    DREADY = 1'b1;
    SVALID = 1'b1;
    SIN    = 1'b0;
    @(posedge CLK);
    #1;
    chk("ff_hand_dout", 32'(DOUT),   32'hFF);
    chk("ff_hand_dv",   32'(DVALID), 32'd1);
    chk("ff_hand_ovf",  32'(OVF),    32'd0);
    @(negedge CLK);
    DREADY = 1'b0;
    consume();

    // Reset after 4 data bits, then 5A
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    @(negedge CLK);
    RESETB = 1'b0;
    SVALID = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    chk("mid_rst_cnt",  32'(dut.cnt_q), 32'd0);
    @(negedge CLK);
    RESETB = 1'b1;
    d = 8'h5A;
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, d[i]);
      chk("5a_no_early", 32'(DVALID), 32'd0);
    end
    step(1'b1, 1'b0);
    chk("5a_dout", 32'(DOUT), 32'h5A);
    chk("5a_perr", 32'(PERR), 32'd0);
    chk("5a_dv",   32'(DVALID), 32'd1);

    // No-parity instance: leading 1 ignored, C3 completes on 9th edge
    do_reset();
    step(1'b1, 1'b1);
    chk("np_ignore_busy", 32'(BUSY2), 32'd0);
    d = 8'hC3;
    step(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, d[i]);
    chk("np_dvalid_8", 32'(DVALID2), 32'd0);
    step(1'b1, d[7]);
    chk("np_dvalid_9", 32'(DVALID2), 32'd1);
    chk("np_dout", 32'(DOUT2), 32'hC3);
    chk("np_perr", 32'(PERR2), 32'd0);
    chk("np_busy", 32'(BUSY2), 32'd0);
    step(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_packer.md
SIPO_PACKER -- requirements
Module: sipo_packer

Interface
REQ-001 The parameter list SHALL be as follows, one per line: name, default, meaning.
- WIDTH, 8, data bits per frame (2..16).
- PARITY_EN, 1, 1 = even-parity bit follows the data bits; 0 = no parity bit.
REQ-002 The ports SHALL be as follows, one per line: name  direction  width  meaning.
- CLK  input  1  single clock, rising edge.
- RESETB  input  1  reset, asynchronous, active-low.
- SIN  input  1  serial data bit, sampled only when SVALID=1.
- SVALID  input  1  qualifies SIN for the current cycle.
- DOUT  output  WIDTH  packed word, LSB = first data bit received.
- PERR  output  1  parity error flag for the word on DOUT; 0 when PARITY_EN=0.
- DVALID  output  1  DOUT/PERR hold a word not yet consumed.
- DREADY  input  1  consumer accepts the word when DVALID=1 and DREADY=1.
- BUSY  output  1  high in every state except IDLE.
- OVF  output  1  one-cycle pulse when a completed word is dropped.

Function
REQ-003 The FSM SHALL have three states: IDLE, SHIFT and PAR; no other state is reachable.
REQ-004 In IDLE, the block SHALL treat an accepted bit (SVALID=1) with SIN=0 as the start bit, move to SHIFT, and clear the bit counter; an accepted SIN=1 SHALL be ignored.
REQ-005 In SHIFT, each accepted bit SHALL be stored at position count, and count SHALL increment by one.
REQ-006 The state after the WIDTH-th data bit SHALL be PAR if PARITY_EN=1, otherwise IDLE.
REQ-007 In PAR, the block SHALL accept one bit, compute PERR = (XOR of data bits) XOR SIN, and return to IDLE.
REQ-008 While SVALID=0, the block SHALL hold its state, counter and shift register unchanged in every state.
REQ-009 A word SHALL be complete at the rising edge that samples its final bit (last data bit or parity bit); DOUT/PERR SHALL load and DVALID SHALL go to 1 at that same edge, giving a latency of 0 cycles after the final sampling edge.
REQ-010 DVALID, DOUT and PERR SHALL stay stable until a cycle with DVALID=1 and DREADY=1, after which DVALID SHALL clear at that edge unless a new word completes at the same edge.
REQ-011 If a word completes while DVALID=1 and DREADY=1, the new word SHALL load, DVALID SHALL remain 1, and OVF SHALL stay 0.
REQ-012 If a word completes while DVALID=1 and DREADY=0, the new word SHALL be dropped, the held word SHALL remain, and OVF SHALL pulse for exactly one cycle.
REQ-013 Deasserting DREADY SHALL never stall serial reception; the input side has no back-pressure.
REQ-014 BUSY SHALL be a registered decode of state (state != IDLE).
REQ-015 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap past WIDTH.

Reset
REQ-016 RESETB=0 SHALL immediately force state=IDLE, count=0, shift register=0, DOUT=0, PERR=0, DVALID=0, BUSY=0, OVF=0.
REQ-017 Reset asserted mid-frame SHALL discard the partial frame, and after release the block SHALL wait for a new start bit.
REQ-018 Every flop SHALL release from reset synchronously with respect to CLK, with no X on any output after release.

Structure
REQ-019 The state encodings (IDLE=2'b00, SHIFT=2'b01, PAR=2'b10) and the default WIDTH SHALL live in a shared package/include used by the RTL and the bench.
REQ-020 The output holding register (DOUT, PERR, DVALID, OVF logic) SHALL be one sub-module, word_hold; the FSM, counter and shift register SHALL stay in the top module.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- WIDTH=8, PARITY_EN=1, SVALID=1 continuous, bits 0 | 1,0,1,0,0,1,0,1 | 0 -> DVALID=1 after the 10th edge, DOUT=8'hA5, PERR=0, BUSY=0.
- Same frame with parity bit 1 -> DOUT=8'hA5, PERR=1.
- Frame 8'h3C with SVALID toggling 1/0 every cycle -> DOUT=8'h3C, completion at the 20th edge, no state change on SVALID=0 cycles.
- Two back-to-back frames 8'h01 then 8'hFF with DREADY=0 throughout -> DOUT stays 8'h01, OVF=1 for exactly one cycle at the second completion; same case with DREADY=1 on that edge -> DOUT=8'hFF, OVF=0.
- RESETB low after 4 data bits, released, then full frame 8'h5A -> only 8'h5A is delivered, with no stale bits.
- PARITY_EN=0, frame 8'hC3 -> DVALID after the 9th edge, PERR=0; a leading SIN=1 in IDLE is ignored.
